aes128_key_expansion_ctrl: RTL and testbench

//  Sequencer for the single-round AES-128 key-schedule datapath. Steps an external

---
 rtl/aes128_key_expansion_ctrl.sv | 159 +++++++++++++++
 tb/tb_aes128_key_expansion_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_key_expansion_ctrl.sv
// Sequencer for a single-round AES-128 key-schedule stage: walks rounds 1..NR,
// banks every round key and serves them through a registered read port.
module aes128_key_expansion_ctrl #(
  parameter int KW = 128,
  parameter int NR = 10,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [KW-1:0] key_i,
  output logic          busy_o,
  output logic          ready_o,
  output logic          done_o,
  output logic [KW-1:0] ks_key_o,
  output logic [IW-1:0] ks_round_o,
  output logic [7:0]    ks_rcon_o,
  input  logic [KW-1:0] ks_next_i,
  input  logic          rd_en_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [KW-1:0] rd_key_o,
  output logic          rd_valid_o,
  output logic          rd_err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_READY} state_t;

  localparam logic [IW-1:0] LAST_RND = IW'(NR);

  state_t        r_state;
  state_t        w_stateNext;
  logic [KW-1:0] r_bank [0:NR];
  logic [KW-1:0] r_curKey;
  logic [IW-1:0] r_rnd;
  logic          r_done;
  logic [KW-1:0] r_rdKey;
  logic          r_rdValid;
  logic          r_rdErr;
  logic          w_busy;
  logic          w_ready;
  logic          w_lastRound;
  logic          w_load;
  logic          w_step;
  logic [7:0]    w_rcon;

  // Abort outranks everything, so it masks both the load and the round step.
  assign w_lastRound = (r_rnd == LAST_RND);
  assign w_load      = !abort_i && start_i && !w_busy;
  assign w_step      = !abort_i && w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_busy      = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_stateNext = ST_EXPAND;
      end
      ST_EXPAND: begin
        w_busy = 1'b1;
        if (w_lastRound) w_stateNext = ST_READY;
      end
      ST_READY: begin
        w_ready = 1'b1;
        if (start_i) w_stateNext = ST_EXPAND;
      end
      default: w_stateNext = ST_IDLE;
    endcase
    if (abort_i) w_stateNext = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_curKey <= '0;
      r_rnd    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_step && w_lastRound;
      if (w_load) begin
        r_curKey <= key_i;
        r_rnd    <= IW'(1);
      end else if (w_step) begin
        r_curKey <= ks_next_i;
        if (!w_lastRound) r_rnd <= r_rnd + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) r_bank[i] <= '0;
    end else if (w_load) begin
      r_bank[0] <= key_i;
    end else if (w_step) begin
      r_bank[r_rnd] <= ks_next_i;
    end
  end

  // Reads see the bank as it was before this edge, so a read issued together
  // with a restart still returns the old schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdKey   <= '0;
      r_rdValid <= 1'b0;
      r_rdErr   <= 1'b0;
    end else begin
      r_rdValid <= 1'b0;
      r_rdErr   <= 1'b0;
      if (rd_en_i) begin
        if (w_ready && (rd_idx_i <= LAST_RND)) begin
          r_rdKey   <= r_bank[rd_idx_i];
          r_rdValid <= 1'b1;
        end else begin
          r_rdKey <= '0;
          r_rdErr <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_rcon = 8'h00;
    if (w_busy) begin
      case (r_rnd)
        IW'(1):  w_rcon = 8'h01;
        IW'(2):  w_rcon = 8'h02;
        IW'(3):  w_rcon = 8'h04;
        IW'(4):  w_rcon = 8'h08;
        IW'(5):  w_rcon = 8'h10;
        IW'(6):  w_rcon = 8'h20;
        IW'(7):  w_rcon = 8'h40;
        IW'(8):  w_rcon = 8'h80;
        IW'(9):  w_rcon = 8'h1b;
        IW'(10): w_rcon = 8'h36;
        default: w_rcon = 8'h00;
      endcase
    end
  end

  assign busy_o     = w_busy;
  assign ready_o    = w_ready;
  assign done_o     = r_done;
  assign ks_key_o   = r_curKey;
  assign ks_round_o = w_busy ? r_rnd : '0;
  assign ks_rcon_o  = w_rcon;
  assign rd_key_o   = r_rdKey;
  assign rd_valid_o = r_rdValid;
  assign rd_err_o   = r_rdErr;

endmodule

// File: tb/tb_aes128_key_expansion_ctrl.sv
// Self-checking bench: attaches a behavioural AES round-key stage to the
// sequencer and compares every cycle against a schedule-level model.
module tb_aes128_key_expansion_ctrl;

  localparam logic [127:0] KEY1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] KEY2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         busy_o, ready_o, done_o;
  logic [127:0] ks_key_o;
  logic [3:0]   ks_round_o;
  logic [7:0]   ks_rcon_o;
  logic [127:0] ks_next_i;
  logic         rd_en_i = 1'b0;
  logic [3:0]   rd_idx_i = '0;
  logic [127:0] rd_key_o;
  logic         rd_valid_o, rd_err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes128_key_expansion_ctrl #(.KW(128), .NR(10), .IW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .key_i(key_i),
    .busy_o(busy_o), .ready_o(ready_o), .done_o(done_o),
    .ks_key_o(ks_key_o), .ks_round_o(ks_round_o), .ks_rcon_o(ks_rcon_o),
    .ks_next_i(ks_next_i), .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i),
    .rd_key_o(rd_key_o), .rd_valid_o(rd_valid_o), .rd_err_o(rd_err_o)
  );

  logic [7:0] sbox [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [7:0] rconLit [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rconFor(input int r);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 1; i < r; i++) v = xtime(v);
    return v;
  endfunction

  // External round-key stage: one AES-128 key-schedule round per cycle.
  always_comb begin
    logic [31:0] t, n0, n1, n2, n3;
    t  = subWord({ks_key_o[23:0], ks_key_o[31:24]}) ^ {ks_rcon_o, 24'h0};
    n0 = ks_key_o[127:96] ^ t;
    n1 = ks_key_o[95:64] ^ n0;
    n2 = ks_key_o[63:32] ^ n1;
    n3 = ks_key_o[31:0] ^ n2;
    ks_next_i = {n0, n1, n2, n3};
  end

  logic [127:0] mSched [0:10];
  int           mPhase = 0;
  int           mStep = 0;
  logic         mDone = 1'b0;
  logic [127:0] mCurKey = '0;
  logic [127:0] mRdKey = '0;
  logic         mRdValid = 1'b0;
  logic         mRdErr = 1'b0;
  bit           modelOn = 1'b0;

  // Whole 44-word FIPS-197 expansion, sliced into eleven round keys.
  function automatic void computeSched(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) mSched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mPhase = 0; mStep = 0; mDone = 1'b0; mCurKey = '0;
      mRdKey = '0; mRdValid = 1'b0; mRdErr = 1'b0; modelOn = 1'b1;
    end else begin
      mRdValid = 1'b0;
      mRdErr   = 1'b0;
      if (rd_en_i) begin
        if (mPhase == 2 && rd_idx_i <= 4'd10) begin
          mRdKey = mSched[rd_idx_i]; mRdValid = 1'b1;
        end else begin
          mRdKey = '0; mRdErr = 1'b1;
        end
      end
      mDone = 1'b0;
      if (abort_i) begin
        mPhase = 0;
      end else if (mPhase == 1) begin
        mCurKey = mSched[mStep];
        if (mStep == 10) begin
          mPhase = 2; mDone = 1'b1;
        end else begin
          mStep++;
        end
      end else if (start_i) begin
        computeSched(key_i);
        mCurKey = key_i; mPhase = 1; mStep = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (modelOn) begin
      checkOutput("m_busy", 128'(busy_o), 128'(mPhase == 1));
      checkOutput("m_ready", 128'(ready_o), 128'(mPhase == 2));
      checkOutput("m_done", 128'(done_o), 128'(mDone));
      checkOutput("m_ks_key", ks_key_o, mCurKey);
      checkOutput("m_ks_round", 128'(ks_round_o), (mPhase == 1) ? 128'(mStep) : 128'(0));
      checkOutput("m_ks_rcon", 128'(ks_rcon_o), (mPhase == 1) ? 128'(rconFor(mStep)) : 128'(0));
      checkOutput("m_rd_valid", 128'(rd_valid_o), 128'(mRdValid));
      checkOutput("m_rd_err", 128'(rd_err_o), 128'(mRdErr));
      checkOutput("m_rd_key", rd_key_o, mRdKey);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic [127:0] k,
                               input logic rd, input logic [3:0] idx);
    start_i = st; abort_i = ab; key_i = k; rd_en_i = rd; rd_idx_i = idx;
    tick();
    start_i = 1'b0; abort_i = 1'b0; rd_en_i = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 128'(busy_o), 128'(0));
    checkOutput({tag, "_ready"}, 128'(ready_o), 128'(0));
    checkOutput({tag, "_done"}, 128'(done_o), 128'(0));
    checkOutput({tag, "_ks_key"}, ks_key_o, 128'(0));
    checkOutput({tag, "_ks_round"}, 128'(ks_round_o), 128'(0));
    checkOutput({tag, "_ks_rcon"}, 128'(ks_rcon_o), 128'(0));
    checkOutput({tag, "_rd_key"}, rd_key_o, 128'(0));
    checkOutput({tag, "_rd_valid"}, 128'(rd_valid_o), 128'(0));
    checkOutput({tag, "_rd_err"}, 128'(rd_err_o), 128'(0));
  endtask

  // Runs an expansion to READY, optionally injecting a start or a read at busy cycle injectAt.
  task automatic waitReady(input string tag, input int injectAt, input logic injStart,
                           input logic [127:0] injKey, input logic injRead);
    int busyCnt;
    busyCnt = 0;
    for (int c = 0; c < 30 && ready_o !== 1'b1; c++) begin
      if (busy_o === 1'b1) begin
        busyCnt++;
        if (busyCnt <= 10) begin
          checkOutput({tag, "_round_lit"}, 128'(ks_round_o), 128'(busyCnt));
          checkOutput({tag, "_rcon_lit"}, 128'(ks_rcon_o), 128'(rconLit[busyCnt-1]));
        end
      end
      if (injectAt != 0 && busyCnt == injectAt) begin
        start_i = injStart; key_i = injKey; rd_en_i = injRead; rd_idx_i = 4'd3;
      end
      tick();
      if (injectAt != 0 && busyCnt == injectAt) begin
        start_i = 1'b0; rd_en_i = 1'b0;
        if (injRead) begin
          checkOutput({tag, "_busyrd_err"}, 128'(rd_err_o), 128'(1));
          checkOutput({tag, "_busyrd_valid"}, 128'(rd_valid_o), 128'(0));
          checkOutput({tag, "_busyrd_key"}, rd_key_o, 128'(0));
        end
      end
    end
    checkOutput({tag, "_ready"}, 128'(ready_o), 128'(1));
    checkOutput({tag, "_done"}, 128'(done_o), 128'(1));
    checkOutput({tag, "_busycnt"}, 128'(busyCnt), 128'(10));
    tick();
    checkOutput({tag, "_done_end"}, 128'(done_o), 128'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 checkAllZero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    applyStimulus(1'b1, 1'b0, KEY1, 1'b0, 4'd0);
    waitReady("t1", 0, 1'b0, '0, 1'b0);

    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd1);
    checkOutput("t2_r1_key", rd_key_o, KEY1_R1);
    checkOutput("t2_r1_valid", 128'(rd_valid_o), 128'(1));
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd10);
    checkOutput("t2_r10_key", rd_key_o, KEY1_R10);
    checkOutput("t2_r10_valid", 128'(rd_valid_o), 128'(1));
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd0);
    checkOutput("t2_r0_key", rd_key_o, KEY1);
    tick();
    checkOutput("t2_hold_key", rd_key_o, KEY1);
    checkOutput("t2_hold_valid", 128'(rd_valid_o), 128'(0));

    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd11);
    checkOutput("t3_idx11_err", 128'(rd_err_o), 128'(1));
    checkOutput("t3_idx11_valid", 128'(rd_valid_o), 128'(0));
    checkOutput("t3_idx11_key", rd_key_o, 128'(0));
    applyStimulus(1'b1, 1'b0, KEY2, 1'b0, 4'd0);
    waitReady("t3", 3, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd1);
    checkOutput("t3_r1_key", rd_key_o, KEY2_R1);

    applyStimulus(1'b1, 1'b0, KEY1, 1'b0, 4'd0);
    for (int c = 0; c < 20 && ks_round_o != 4'd5; c++) tick();
    checkOutput("t5_at_round5", 128'(ks_round_o), 128'(5));
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 4'd0);
    checkOutput("t5_abort_busy", 128'(busy_o), 128'(0));
    checkOutput("t5_abort_ready", 128'(ready_o), 128'(0));
    for (int c = 0; c < 8; c++) begin
      checkOutput("t5_no_done", 128'(done_o), 128'(0));
      tick();
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd1);
    checkOutput("t5_idle_rd_err", 128'(rd_err_o), 128'(1));
    applyStimulus(1'b1, 1'b0, KEY2, 1'b0, 4'd0);
    waitReady("t5", 0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd10);
    checkOutput("t5_r10_key", rd_key_o, KEY2_R10);

    applyStimulus(1'b1, 1'b0, KEY1, 1'b1, 4'd0);
    checkOutput("t6_old_key", rd_key_o, KEY2);
    checkOutput("t6_old_valid", 128'(rd_valid_o), 128'(1));
    checkOutput("t6_started", 128'(busy_o), 128'(1));
    waitReady("t6", 4, 1'b1, 128'hdeadbeef, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 4'd10);
    checkOutput("t6_r10_key", rd_key_o, KEY1_R10);

    applyStimulus(1'b1, 1'b0, KEY2, 1'b0, 4'd0);
    tick();
    tick();
    rst_n = 1'b0;
    #1 checkAllZero("t6_midrst");
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
